// File: rtl/load_use_stall_controller.sv
// Load-use hazard detector with a multi-cycle bubble FSM, a memory-busy
// pipeline freeze and a saturating count of inserted bubbles.
module load_use_stall_controller #(
  parameter int NUM_SRC           = 2,
  parameter int ADDR_WIDTH        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int IGNORE_X0         = 1,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [ADDR_WIDTH-1:0]         REG_WRITE_ADDR_EX,
  input  logic                          MEM_READ_EN_EX,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] ADDR_ID,
  input  logic [NUM_SRC-1:0]            OP_SEL_ID,
  input  logic                          MEM_BUSY,
  output logic                          LU_HAZARD,
  output logic                          PC_WRITE_EN,
  output logic                          IF_ID_WRITE_EN,
  output logic                          ID_EX_BUBBLE,
  output logic                          PIPE_FREEZE,
  output logic [CNT_WIDTH-1:0]          STALL_COUNT
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] LU_STALL = 1'b1;
  localparam logic [3:0] REM_INIT = 4'(LOAD_STALL_CYCLES - 1);

  logic [0:0]           state_reg, state_next;
  logic [3:0]           rem_reg, rem_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [NUM_SRC-1:0]   match;
  logic                 x0_block;

  // A load to x0 never produces a usable value, so it cannot create a hazard.
  assign x0_block = (IGNORE_X0 != 0) && (REG_WRITE_ADDR_EX == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_match
      assign match[gi] = MEM_READ_EN_EX && !OP_SEL_ID[gi] && !x0_block &&
                         (ADDR_ID[gi*ADDR_WIDTH +: ADDR_WIDTH] == REG_WRITE_ADDR_EX);
    end
  endgenerate

  assign LU_HAZARD = !RESET && (|match);

  always_comb begin
    PC_WRITE_EN    = 1'b1;
    IF_ID_WRITE_EN = 1'b1;
    ID_EX_BUBBLE   = 1'b0;
    PIPE_FREEZE    = 1'b0;
    if (RESET) begin
      PC_WRITE_EN    = 1'b1;
    end else if (MEM_BUSY) begin
      PIPE_FREEZE    = 1'b1;
      PC_WRITE_EN    = 1'b0;
      IF_ID_WRITE_EN = 1'b0;
    end else if (state_reg == LU_STALL || LU_HAZARD) begin
      PC_WRITE_EN    = 1'b0;
      IF_ID_WRITE_EN = 1'b0;
      ID_EX_BUBBLE   = 1'b1;
    end
  end

  // A memory freeze holds the FSM exactly where it is.
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    if (!MEM_BUSY) begin
      if (state_reg == IDLE) begin
        if (LU_HAZARD && LOAD_STALL_CYCLES > 1) begin
          state_next = LU_STALL;
          rem_next   = REM_INIT;
        end
      end else begin
        rem_next = rem_reg - 4'd1;
        if (rem_reg == 4'd1) begin
          state_next = IDLE;
        end
      end
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (ID_EX_BUBBLE && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      rem_reg   <= 4'd0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign STALL_COUNT = cnt_reg;

endmodule

// File: tb/tb_load_use_stall_controller.sv
// Directed bench over four parameterisations; expectations queued at drive
// time and checked on the following falling edge.
module tb_load_use_stall_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ex_addr [4];
  logic        ld      [4];
  logic [9:0]  addr_id [4];
  logic [1:0]  op_sel  [4];
  logic        busy    [4];
  logic        hz      [4];
  logic        pc_we   [4];
  logic        ifid_we [4];
  logic        bub     [4];
  logic        frz     [4];
  logic [15:0] cnt_w   [4];
  logic [15:0] cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;

  typedef struct {
    string       tag;
    int          k;
    logic [4:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = cnt1;
  assign cnt_w[2] = cnt2;
  assign cnt_w[3] = {14'd0, cnt3};

  load_use_stall_controller u_def (
    .CLK(clk), .RESET(rst), .REG_WRITE_ADDR_EX(ex_addr[0]), .MEM_READ_EN_EX(ld[0]),
    .ADDR_ID(addr_id[0]), .OP_SEL_ID(op_sel[0]), .MEM_BUSY(busy[0]),
    .LU_HAZARD(hz[0]), .PC_WRITE_EN(pc_we[0]), .IF_ID_WRITE_EN(ifid_we[0]),
    .ID_EX_BUBBLE(bub[0]), .PIPE_FREEZE(frz[0]), .STALL_COUNT(cnt0));

  load_use_stall_controller #(.IGNORE_X0(0)) u_x0 (
    .CLK(clk), .RESET(rst), .REG_WRITE_ADDR_EX(ex_addr[1]), .MEM_READ_EN_EX(ld[1]),
    .ADDR_ID(addr_id[1]), .OP_SEL_ID(op_sel[1]), .MEM_BUSY(busy[1]),
    .LU_HAZARD(hz[1]), .PC_WRITE_EN(pc_we[1]), .IF_ID_WRITE_EN(ifid_we[1]),
    .ID_EX_BUBBLE(bub[1]), .PIPE_FREEZE(frz[1]), .STALL_COUNT(cnt1));

  load_use_stall_controller #(.LOAD_STALL_CYCLES(3)) u_lsc3 (
    .CLK(clk), .RESET(rst), .REG_WRITE_ADDR_EX(ex_addr[2]), .MEM_READ_EN_EX(ld[2]),
    .ADDR_ID(addr_id[2]), .OP_SEL_ID(op_sel[2]), .MEM_BUSY(busy[2]),
    .LU_HAZARD(hz[2]), .PC_WRITE_EN(pc_we[2]), .IF_ID_WRITE_EN(ifid_we[2]),
    .ID_EX_BUBBLE(bub[2]), .PIPE_FREEZE(frz[2]), .STALL_COUNT(cnt2));

  load_use_stall_controller #(.CNT_WIDTH(2)) u_sat (
    .CLK(clk), .RESET(rst), .REG_WRITE_ADDR_EX(ex_addr[3]), .MEM_READ_EN_EX(ld[3]),
    .ADDR_ID(addr_id[3]), .OP_SEL_ID(op_sel[3]), .MEM_BUSY(busy[3]),
    .LU_HAZARD(hz[3]), .PC_WRITE_EN(pc_we[3]), .IF_ID_WRITE_EN(ifid_we[3]),
    .ID_EX_BUBBLE(bub[3]), .PIPE_FREEZE(frz[3]), .STALL_COUNT(cnt3));

  // ctl bit order: {LU_HAZARD, PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_BUBBLE, PIPE_FREEZE}
  localparam logic [4:0] C_RUN   = 5'b01100;
  localparam logic [4:0] C_HAZ   = 5'b10010;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_FRZ   = 5'b00001;
  localparam logic [4:0] C_HFRZ  = 5'b10001;

  task automatic step(input string tag, input int k, input logic r,
                      input logic [4:0] ex, input logic l, input logic [4:0] a1,
                      input logic [4:0] a0, input logic [1:0] os, input logic bz,
                      input logic [4:0] ectl, input logic [15:0] ecnt);
    exp_t e;
    exp_t got;
    logic [4:0] octl;
    @(posedge clk);
    #1;
    rst = r;
    for (int j = 0; j < 4; j++) begin
      ld[j]   = 1'b0;
      busy[j] = 1'b0;
    end
    ex_addr[k] = ex;
    ld[k]      = l;
    addr_id[k] = {a1, a0};
    op_sel[k]  = os;
    busy[k]    = bz;
    e.tag = tag; e.k = k; e.ctl = ectl; e.cnt = ecnt;
    q.push_back(e);
    @(negedge clk);
    got  = q.pop_front();
    octl = {hz[got.k], pc_we[got.k], ifid_we[got.k], bub[got.k], frz[got.k]};
    checks++;
    assert (octl === got.ctl) else begin
      errors++;
      $error("FAIL %s ctl: observed=%b expected=%b", got.tag, octl, got.ctl);
    end
    checks++;
    assert (cnt_w[got.k] === got.cnt) else begin
      errors++;
      $error("FAIL %s count: observed=%0d expected=%0d", got.tag, cnt_w[got.k], got.cnt);
    end
    $display("step %-12s inst=%0d ctl=%b count=%0d", got.tag, got.k, octl, cnt_w[got.k]);
  endtask

  initial begin
    for (int j = 0; j < 4; j++) begin
      ex_addr[j] = '0; ld[j] = 1'b0; addr_id[j] = '0; op_sel[j] = '0; busy[j] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Hazard inputs present while in reset must not show through.
    step("reset",     0, 1'b1, 5'd5, 1'b1, 5'd7, 5'd5, 2'b00, 1'b0, C_RUN, 16'd0);
    step("haz_x5",    0, 1'b0, 5'd5, 1'b1, 5'd7, 5'd5, 2'b00, 1'b0, C_HAZ, 16'd0);
    step("after_haz", 0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN, 16'd1);
    step("op0_imm",   0, 1'b0, 5'd5, 1'b1, 5'd7, 5'd5, 2'b01, 1'b0, C_RUN, 16'd1);
    step("op1_imm",   0, 1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 2'b10, 1'b0, C_HAZ, 16'd1);
    step("idle",      0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN, 16'd2);
    step("x0_ignore", 0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN, 16'd2);
    step("no_load",   0, 1'b0, 5'd5, 1'b0, 5'd5, 5'd5, 2'b00, 1'b0, C_RUN, 16'd2);
    step("busy_haz",  0, 1'b0, 5'd9, 1'b1, 5'd9, 5'd1, 2'b00, 1'b1, C_HFRZ, 16'd2);
    step("busy_end",  0, 1'b0, 5'd9, 1'b1, 5'd9, 5'd1, 2'b00, 1'b0, C_HAZ, 16'd2);
    step("busy_done", 0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN, 16'd3);

    step("x0_active", 1, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, C_HAZ, 16'd0);
    step("x0_after",  1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN, 16'd1);

    step("l3_c0",     2, 1'b0, 5'd5, 1'b1, 5'd7, 5'd5, 2'b00, 1'b0, C_HAZ,   16'd0);
    step("l3_c1",     2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_STALL, 16'd1);
    step("l3_c2",     2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_STALL, 16'd2);
    step("l3_c3",     2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN,   16'd3);

    // Freeze in the middle of a stall, plus hazard inputs ignored in LU_STALL.
    step("fz_c0",     2, 1'b0, 5'd3, 1'b1, 5'd3, 5'd4, 2'b00, 1'b0, C_HAZ,   16'd3);
    step("fz_c1",     2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1, C_FRZ,   16'd4);
    step("fz_c2",     2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1, C_FRZ,   16'd4);
    step("fz_c3",     2, 1'b0, 5'd3, 1'b1, 5'd3, 5'd4, 2'b00, 1'b0, C_HAZ,   16'd4);
    step("fz_c4",     2, 1'b0, 5'd3, 1'b1, 5'd3, 5'd4, 2'b00, 1'b0, C_HAZ,   16'd5);
    step("fz_c5",     2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN,   16'd6);

    step("rs_c0",     2, 1'b0, 5'd6, 1'b1, 5'd6, 5'd6, 2'b00, 1'b0, C_HAZ,   16'd6);
    step("rs_c1",     2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_STALL, 16'd7);
    step("rs_c2",     2, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN,   16'd8);
    step("rs_c3",     2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN,   16'd0);
    step("rs_c4",     2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN,   16'd0);

    for (int h = 0; h < 5; h++) begin
      step("sat_haz",  3, 1'b0, 5'd2, 1'b1, 5'd0, 5'd2, 2'b00, 1'b0, C_HAZ,
           16'((h < 3) ? h : 3));
      step("sat_idle", 3, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, C_RUN,
           16'((h + 1 < 3) ? h + 1 : 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
